// File: rtl/binary_div_pkg.sv
// binary_div_pkg
// Shared definitions for the sequential signed divider.
//   state_t / IDLE, CALC, FIX : FSM state encodings
//   MAX_W                     : widest operand the helpers handle
//   condNeg()                 : conditional two's-complement negate, used
//                               both for taking magnitudes and for the
//                               final sign fix
package binary_div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIX  = 2'd2;

  localparam int MAX_W = 64;

  // Callers zero-extend a WIDTH-bit value to MAX_W and truncate the result
  // back to WIDTH bits. The low WIDTH bits of a negation do not depend on
  // the discarded upper bits, so this serves any WIDTH up to MAX_W.
  function automatic logic [MAX_W-1:0] condNeg(input logic [MAX_W-1:0] v,
                                               input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/binary_div_step.sv
// binary_div_step
// One combinational restoring-division step on unsigned magnitudes.
//   remIn_i   [WIDTH:0]   : partial remainder before the step
//   dvdBit_i              : next dividend bit shifted in at the LSB
//   dvsMag_i  [WIDTH-1:0] : divisor magnitude
//   remOut_o  [WIDTH:0]   : partial remainder after the step
//   qBit_o                : quotient bit produced by this step
module binary_div_step
  import binary_div_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH:0]   remIn_i,
  input  logic             dvdBit_i,
  input  logic [WIDTH-1:0] dvsMag_i,
  output logic [WIDTH:0]   remOut_o,
  output logic             qBit_o
);

  // The shift is formed one bit wider than the remainder register so that
  // the compare and subtract never lose a carry; the remainder is always
  // below the divisor between steps, so the result fits back in WIDTH+1.
  logic [WIDTH+1:0] shifted;

  assign shifted  = {remIn_i, dvdBit_i};
  assign qBit_o   = (shifted >= (WIDTH+2)'(dvsMag_i));
  assign remOut_o = qBit_o ? (WIDTH+1)'(shifted - (WIDTH+2)'(dvsMag_i))
                           : (WIDTH+1)'(shifted);

endmodule

// File: rtl/binary_div_seq_bi.sv
// binary_div_seq_bi
// Sequential signed two's-complement divider (restoring, one quotient bit
// per cycle, then a sign-fix cycle). Quotient truncates toward zero; the
// remainder takes the dividend's sign.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : global enable; every register holds while low
//   start       : request, accepted only in IDLE with en high
//   N, D        : signed dividend / divisor, captured on accepted start
//   Q, R        : registered signed quotient / remainder
//   busy        : operation in progress
//   done        : one enabled cycle pulse when Q/R/flags update
//   dbz, ovf    : divide-by-zero / overflow flags, held until next done
// Build option: define BINARY_DIV_EARLY_DBZ_EN to send a zero divisor
// straight from IDLE to FIX, skipping the CALC steps.
module binary_div_seq_bi
  import binary_div_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             signN_q, signN_d;
  logic             signD_q, signD_d;
  logic             dbzCap_q, dbzCap_d;
  logic             ovfCap_q, ovfCap_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] qOut_q, qOut_d;
  logic [WIDTH-1:0] rOut_q, rOut_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] nMag, dMag;
  logic             dIsZero;
  logic [WIDTH:0]   stepRem;
  logic             stepQ;

  assign nMag    = WIDTH'(condNeg(MAX_W'(N), N[WIDTH-1]));
  assign dMag    = WIDTH'(condNeg(MAX_W'(D), D[WIDTH-1]));
  assign dIsZero = (D == '0);

  binary_div_step #(.WIDTH(WIDTH)) u_step (
    .remIn_i  (rem_q),
    .dvdBit_i (dvd_q[WIDTH-1]),
    .dvsMag_i (dvs_q),
    .remOut_o (stepRem),
    .qBit_o   (stepQ)
  );

  // Next-state logic. FIX writes the sign-corrected result back into the
  // quotient/remainder registers and raises pend; the following enabled
  // edge copies it to the outputs with done. That extra stage lets a new
  // start be accepted on the same edge the previous result is published.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    signN_d  = signN_q;
    signD_d  = signD_q;
    dbzCap_d = dbzCap_q;
    ovfCap_d = ovfCap_q;
    pend_d   = 1'b0;
    qOut_d   = qOut_q;
    rOut_d   = rOut_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    busy_d   = (state_q != IDLE);
    done_d   = 1'b0;

    if (pend_q) begin
      qOut_d = quot_q;
      rOut_d = rem_q[WIDTH-1:0];
      dbz_d  = dbzCap_q;
      ovf_d  = ovfCap_q;
      done_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          signN_d  = N[WIDTH-1];
          signD_d  = D[WIDTH-1];
          dvd_d    = nMag;
          dvs_d    = dMag;
          rem_d    = '0;
          quot_d   = '0;
          cnt_d    = CW'(WIDTH - 1);
          dbzCap_d = dIsZero;
          ovfCap_d = (N == {1'b1, {(WIDTH-1){1'b0}}}) && (D == '1);
`ifdef BINARY_DIV_EARLY_DBZ_EN
          // The remainder of a divide by zero is the dividend itself, so
          // the magnitude is loaded directly and FIX applies the sign.
          if (dIsZero) begin
            rem_d   = {1'b0, nMag};
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
`else
          state_d  = CALC;
`endif
        end
      end
      CALC: begin
        rem_d  = stepRem;
        quot_d = {quot_q[WIDTH-2:0], stepQ};
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quot_d  = dbzCap_q ? '1
                           : WIDTH'(condNeg(MAX_W'(quot_q), signN_q ^ signD_q));
        rem_d   = {1'b0, WIDTH'(condNeg(MAX_W'(rem_q[WIDTH-1:0]), signN_q))};
        pend_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including the done pulse, freezes while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      signN_q  <= 1'b0;
      signD_q  <= 1'b0;
      dbzCap_q <= 1'b0;
      ovfCap_q <= 1'b0;
      pend_q   <= 1'b0;
      qOut_q   <= '0;
      rOut_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      signN_q  <= signN_d;
      signD_q  <= signD_d;
      dbzCap_q <= dbzCap_d;
      ovfCap_q <= ovfCap_d;
      pend_q   <= pend_d;
      qOut_q   <= qOut_d;
      rOut_q   <= rOut_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Q    = qOut_q;
  assign R    = rOut_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_binary_div_seq_bi.sv
// tb_binary_div_seq_bi
// Scoreboard bench for binary_div_seq_bi (WIDTH=3). The driver predicts
// which starts are accepted, pushes the arithmetic result into a queue,
// and an independent monitor pops and compares on every done pulse.
// Honours BINARY_DIV_EARLY_DBZ_EN for the zero-divisor latency.
module tb_binary_div_seq_bi;

  localparam int W = 3;
`ifdef BINARY_DIV_EARLY_DBZ_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           doneAt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] nIn = '0;
  logic [W-1:0] dIn = '0;
  logic [W-1:0] qOut, rOut;
  logic         busy, done, dbz, ovf;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   enCyc = 0;
  int   freeAt = 0;
  bit   doneSeen = 1'b0;

  always #5 clk = ~clk;

  binary_div_seq_bi #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .N     (nIn),
    .D     (dIn),
    .Q     (qOut),
    .R     (rOut),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  // Counts clock edges on which the design actually advances.
  always @(posedge clk) begin
    if (en && rst_n) enCyc++;
  end

  // Reference result from plain signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] nb, input logic [W-1:0] db,
                                 input int acc);
    exp_t e;
    int n, d, qi, ri;
    n = int'($signed(nb));
    d = int'($signed(db));
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (d == 0) begin
      qi = -1; ri = n; e.dbz = 1'b1;
    end else if (n == -(1 << (W-1)) && d == -1) begin
      qi = n; ri = 0; e.ovf = 1'b1;
    end else begin
      qi = n / d; ri = n % d;
    end
    e.q = W'(qi);
    e.r = W'(ri);
    e.doneAt = acc + ((d == 0 && EARLY) ? 2 : W + 2);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives one cycle (called just after a falling edge, returns at the next
  // falling edge) and records the expected result if the start is taken.
  task automatic applyStimulus(input logic s, input logic [W-1:0] n,
                               input logic [W-1:0] d);
    exp_t e;
    start = s;
    nIn   = n;
    dIn   = d;
    if (s && en && rst_n && (enCyc + 1 >= freeAt)) begin
      e = model(n, d, enCyc + 1);
      sb.push_back(e);
      freeAt = e.doneAt;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int left;
    left = budget;
    while (sb.size() > 0 && left > 0) begin
      applyStimulus(1'b0, '0, '0);
      left--;
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: one comparison set per done pulse, however long it is held.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done && !doneSeen) begin
      doneSeen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done actual=1 required=0 Q=%0h R=%0h", qOut, rOut);
      end else begin
        e = sb.pop_front();
        checkOutput("Q", qOut, e.q);
        checkOutput("R", rOut, e.r);
        checkOutput("dbz", dbz, e.dbz);
        checkOutput("ovf", ovf, e.ovf);
        checkOutput("latency", enCyc, e.doneAt);
      end
    end else if (!done) begin
      doneSeen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;

    // Reset state
    en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_Q", qOut, 0);
    checkOutput("rst_R", rOut, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dbz", dbz, 0);
    checkOutput("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3/2 with the busy window traced cycle by cycle
    applyStimulus(1'b1, 3'd3, 3'd2);
    for (int i = 0; i <= 5; i++) begin
      checkOutput("busy_window", busy, (i >= 1 && i <= 4));
      applyStimulus(1'b0, '0, '0);
    end
    waitDrain(20);

    // Sign combinations, overflow and divide by zero
    applyStimulus(1'b1, 3'b101, 3'd2); waitDrain(20);
    applyStimulus(1'b1, 3'd3, 3'b110); waitDrain(20);
    applyStimulus(1'b1, 3'b100, 3'd3); waitDrain(20);
    applyStimulus(1'b1, 3'b100, 3'b111); waitDrain(20);
    applyStimulus(1'b1, 3'd3, 3'd0); waitDrain(20);
    applyStimulus(1'b1, 3'b100, 3'd0); waitDrain(20);

    // Start held every cycle: only starts in IDLE are taken
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 3'd2, 3'd1);
    waitDrain(20);

    // Async reset in the middle of CALC aborts with no done
    applyStimulus(1'b1, 3'd3, 3'd1);
    applyStimulus(1'b0, '0, '0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    freeAt = 0;
    #1;
    checkOutput("abort_Q", qOut, 0);
    checkOutput("abort_R", rOut, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_dbz", dbz, 0);
    checkOutput("abort_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) applyStimulus(1'b0, '0, '0);

    // en low for 3 cycles mid-CALC stretches latency by exactly 3 cycles
    applyStimulus(1'b1, 3'b101, 3'b110);
    applyStimulus(1'b0, '0, '0);
    en = 1'b0;
    repeat (3) applyStimulus(1'b0, '0, '0);
    en = 1'b1;
    cyc = 4;
    while (!done && cyc < 30) begin
      applyStimulus(1'b0, '0, '0);
      cyc++;
    end
    checkOutput("stall_latency", cyc, W + 2 + 3);
    waitDrain(20);

    // done is held while en is low and drops on the next enabled edge
    applyStimulus(1'b1, 3'd1, 3'd1);
    cyc = 0;
    while (!done && cyc < 30) begin
      applyStimulus(1'b0, '0, '0);
      cyc++;
    end
    en = 1'b0;
    applyStimulus(1'b0, '0, '0);
    checkOutput("done_stretch", done, 1);
    applyStimulus(1'b0, '0, '0);
    checkOutput("done_stretch", done, 1);
    en = 1'b1;
    applyStimulus(1'b0, '0, '0);
    checkOutput("done_clear", done, 0);
    waitDrain(20);

    // Randomised traffic with occasional enable drops
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    end
    en = 1'b1;
    waitDrain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
